countdown_display: RTL and testbench

- Downstream stage of the traffic controller. Consumes its 6-bit `countdown` and a yellow-phase flag, and drives a 2-digit multiplexed 7-segment display.
- Converts binary to BCD with a sequential double-dabble FSM, then scans the two digits with leading-zero blanking.
- Blinks the display during yellow when the remaining count is at or below a threshold.

---
 rtl/countdown_display.sv | 161 ++++++++++++++++
 tb/tb_countdown_display.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_display.sv
// countdown_display
//   Downstream display stage for the traffic controller. Converts the 6-bit
//   binary countdown to BCD with a sequential double-dabble FSM and scans the
//   result onto a 2-digit multiplexed 7-segment display. Leading zeros are
//   blanked, and the display blinks during yellow when the value is low.
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous, active-low reset
//   countdown  binary remaining seconds, 0..63
//   yellow     high while either road shows yellow
//   seg        segments {a,b,c,d,e,f,g}, bit6 = a, active-high (registered)
//   dig_sel    active-low digit enables: 10 = ones, 01 = tens, 11 = none
//   bcd_valid  one-cycle pulse when new tens/ones are loaded
module countdown_display #(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned BLINK_DIV = 16,
  parameter int unsigned BLINK_TH  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] countdown,
  input  logic       yellow,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       bcd_valid
);

  localparam int unsigned SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  typedef enum logic {DIG_ONES, DIG_TENS} digit_t;

  state_t        state;
  logic          first;      // forces a conversion on the first edge after reset
  logic [5:0]    last_val;
  logic [5:0]    shreg;
  logic [7:0]    acc;
  logic [2:0]    iter;
  logic [3:0]    tens;
  logic [3:0]    ones;

  logic [SW-1:0] scan_cnt;
  digit_t        digit;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  logic [13:0]   dd_next;
  logic [3:0]    adj_hi;
  logic [3:0]    adj_lo;
  logic [31:0]   disp_val;
  logic          blank_now;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1111110;
      4'd1:    seg_of = 7'b0110000;
      4'd2:    seg_of = 7'b1101101;
      4'd3:    seg_of = 7'b1111001;
      4'd4:    seg_of = 7'b0110011;
      4'd5:    seg_of = 7'b1011011;
      4'd6:    seg_of = 7'b1011111;
      4'd7:    seg_of = 7'b1110000;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1111011;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  // One double-dabble iteration: add-3 correction on each BCD nibble, then
  // shift the {accumulator, binary} pair left by one.
  always_comb begin
    adj_hi  = acc[7:4];
    adj_lo  = acc[3:0];
    if (adj_hi >= 4'd5) adj_hi = adj_hi + 4'd3;
    if (adj_lo >= 4'd5) adj_lo = adj_lo + 4'd3;
    dd_next = {adj_hi, adj_lo, shreg} << 1;
  end

  always_comb begin
    disp_val  = 32'(tens) * 32'd10 + 32'(ones);
    blank_now = yellow && (disp_val <= BLINK_TH) && !blink_on;
  end

  // Converter FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      first     <= 1'b1;
      last_val  <= '0;
      shreg     <= '0;
      acc       <= '0;
      iter      <= '0;
      tens      <= '0;
      ones      <= '0;
      bcd_valid <= 1'b0;
    end else begin
      first     <= 1'b0;
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (first || (countdown != last_val)) begin
            last_val <= countdown;
            shreg    <= countdown;
            acc      <= '0;
            iter     <= '0;
            state    <= CONV;
          end
        end
        CONV: begin
          acc   <= dd_next[13:6];
          shreg <= dd_next[5:0];
          iter  <= iter + 3'd1;
          if (iter == 3'd5) state <= LOAD;
        end
        LOAD: begin
          tens      <= acc[7:4];
          ones      <= acc[3:0];
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit scan, blink timebase and registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit     <= DIG_ONES;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      seg       <= '0;
      dig_sel   <= 2'b11;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        digit    <= (digit == DIG_ONES) ? DIG_TENS : DIG_ONES;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (digit == DIG_TENS) begin
        dig_sel <= 2'b01;
        seg     <= (blank_now || (tens == 4'd0)) ? '0 : seg_of(tens);
      end else begin
        dig_sel <= 2'b10;
        seg     <= blank_now ? '0 : seg_of(ones);
      end
    end
  end

endmodule

// File: tb/tb_countdown_display.sv
// Directed testbench for countdown_display with immediate-assertion checks.
module tb_countdown_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] countdown;
  logic       yellow;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       bcd_valid;

  int tests = 0;
  int fails = 0;

  countdown_display #(.SCAN_DIV(4), .BLINK_DIV(16), .BLINK_TH(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .countdown(countdown),
    .yellow   (yellow),
    .seg      (seg),
    .dig_sel  (dig_sel),
    .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges until bcd_valid is seen high (0 on timeout).
  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bcd_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Check one tens-slot and one ones-slot pattern after new values are shown.
  task automatic show(input string tag, input logic [6:0] tseg, input logic [6:0] oseg);
    tick();
    for (int i = 0; i < 20 && dig_sel !== 2'b01; i++) tick();
    chk({tag, "_tsel"}, dig_sel, 2'b01);
    chk({tag, "_tseg"}, seg, tseg);
    for (int i = 0; i < 20 && dig_sel !== 2'b10; i++) tick();
    chk({tag, "_osel"}, dig_sel, 2'b10);
    chk({tag, "_oseg"}, seg, oseg);
  endtask

  // Over 64 cycles (two blink periods) tally ones-slot segment values.
  task automatic blink_count(input logic [6:0] lit, output int n_lit, output int n_off,
                             output int n_other);
    n_lit = 0; n_off = 0; n_other = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (dig_sel == 2'b10) begin
        if (seg == lit) n_lit++;
        else if (seg == 7'b0) n_off++;
        else n_other++;
      end
    end
  endtask

  int n, a, b, c;

  initial begin
    reset     = 1'b1;
    countdown = 6'd45;
    yellow    = 1'b0;
    #1 reset  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_seg", seg, 7'b0);
    chk("rst_sel", dig_sel, 2'b11);
    chk("rst_valid", bcd_valid, 1'b0);

    // Release away from the edge; first edge starts conversion of 45
    @(negedge clk) reset = 1'b1;
    wait_valid(n);
    chk("rst_latency", n, 8);
    chk("rst_tens", dut.tens, 4);
    chk("rst_ones", dut.ones, 5);
    tick();
    chk("valid_one_cycle", bcd_valid, 1'b0);

    // Scan: tens slot 4 cycles, then ones slot 4 cycles
    for (int i = 0; i < 20 && dig_sel !== 2'b01; i++) tick();
    for (int i = 0; i < 4; i++) begin
      chk("scan45_t", {dig_sel, seg}, {2'b01, 7'b0110011});
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("scan45_o", {dig_sel, seg}, {2'b10, 7'b1011011});
      tick();
    end

    // Leading-zero blanking and max value
    countdown = 6'd9;
    wait_valid(n);
    chk("v9_latency", n, 8);
    show("v9", 7'b0000000, 7'b1111011);
    countdown = 6'd63;
    wait_valid(n);
    chk("v63_latency", n, 8);
    chk("v63_tens", dut.tens, 6);
    chk("v63_ones", dut.ones, 3);
    show("v63", 7'b1011111, 7'b1111001);

    // Zero shows "0" in the ones slot
    countdown = 6'd0;
    wait_valid(n);
    show("v0", 7'b0000000, 7'b1111110);

    // Mid-conversion change: 20 then 19 during the 3rd CONV cycle
    countdown = 6'd20;
    tick(); tick(); tick();
    countdown = 6'd19;
    wait_valid(n);
    chk("mid_first_lat", n, 5);
    chk("mid_first_val", {dut.tens, dut.ones}, 8'h20);
    wait_valid(n);
    chk("mid_second_lat", n, 8);
    chk("mid_second_val", {dut.tens, dut.ones}, 8'h19);

    // Blink at value 3 during yellow
    yellow    = 1'b1;
    countdown = 6'd3;
    wait_valid(n);
    tick(); tick();
    blink_count(7'b1111001, a, b, c);
    chk("blink3_lit", a, 16);
    chk("blink3_off", b, 16);
    chk("blink3_other", c, 0);

    // Above threshold: no blanking
    countdown = 6'd4;
    wait_valid(n);
    tick(); tick();
    blink_count(7'b0110011, a, b, c);
    chk("blink4_lit", a, 32);
    chk("blink4_off", b, 0);

    // Yellow low at value 3: no blanking
    countdown = 6'd3;
    wait_valid(n);
    yellow = 1'b0;
    tick(); tick();
    blink_count(7'b1111001, a, b, c);
    chk("noyel_lit", a, 32);
    chk("noyel_off", b, 0);

    // Reset mid-conversion of 37
    countdown = 6'd37;
    tick(); tick();
    chk("mid_rst_inconv", dut.state, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_sel", dig_sel, 2'b11);
    chk("async_seg", seg, 7'b0);
    chk("async_ones", dut.ones, 0);
    chk("async_state", dut.state, 0);
    tick(); tick();
    @(negedge clk) reset = 1'b1;
    wait_valid(n);
    chk("rst37_latency", n, 8);
    chk("rst37_val", {dut.tens, dut.ones}, 8'h37);
    show("v37", 7'b1111001, 7'b1110000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
